// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: control from the pipeline, SRAM port and the decode handshake.
interface inst_fetch_if #(
  parameter int unsigned ADDR_W = 30
);
  logic              RUN;
  logic              REDIR_EN;
  logic [ADDR_W-1:0] REDIR_PC;
  logic              IREQ;
  logic [ADDR_W-1:0] IADDR;
  logic [31:0]       INSTR;
  logic              IF_VALID;
  logic [31:0]       IF_INSTR;
  logic [ADDR_W-1:0] IF_PC;
  logic              ID_READY;

  modport master (
    output RUN, REDIR_EN, REDIR_PC, INSTR, ID_READY,
    input  IREQ, IADDR, IF_VALID, IF_INSTR, IF_PC
  );

  modport slave (
    input  RUN, REDIR_EN, REDIR_PC, INSTR, ID_READY,
    output IREQ, IADDR, IF_VALID, IF_INSTR, IF_PC
  );
endinterface

// File: rtl/inst_fetch.sv
// RISC_TOY instruction fetch: PC, 1-cycle-latency SRAM request, {INSTR,PC} buffer to decode.
module inst_fetch #(
  parameter int unsigned       ADDR_W   = 30,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2
) (
  input logic         CLK,
  input logic         RST,
  inst_fetch_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d, tag_q, tag_d;
  logic              inflight_q, inflight_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       buf_instr_q [DEPTH];
  logic [ADDR_W-1:0] buf_pc_q    [DEPTH];
  logic [31:0]       hold_instr_q;
  logic [ADDR_W-1:0] hold_pc_q;

  logic              head_valid, pop, push, issue;
  logic [CW:0]       occ;
  logic [31:0]       head_instr;
  logic [ADDR_W-1:0] head_pc;

  always_comb begin
    head_valid = (count_q != '0);
    pop        = head_valid & bus.ID_READY;
    // A return arriving in a redirect cycle belongs to the old stream and is dropped.
    push       = inflight_q & ~bus.REDIR_EN;
    occ        = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    issue      = bus.RUN & ~bus.REDIR_EN & (occ < (CW + 1)'(DEPTH));
    head_instr = head_valid ? buf_instr_q[rptr_q] : hold_instr_q;
    head_pc    = head_valid ? buf_pc_q[rptr_q]    : hold_pc_q;

    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (bus.REDIR_EN) begin
      pc_d    = bus.REDIR_PC & ~ADDR_W'(3);
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (issue) begin
        pc_d  = pc_q + ADDR_W'(4);
        tag_d = pc_q;
      end
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q         <= RESET_PC;
      tag_q        <= '0;
      inflight_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      tag_q        <= tag_d;
      inflight_q   <= inflight_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      // Tracks whatever decode last saw so outputs hold once the buffer empties.
      hold_instr_q <= head_instr;
      hold_pc_q    <= head_pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      buf_instr_q[wptr_q] <= bus.INSTR;
      buf_pc_q[wptr_q]    <= tag_q;
    end
  end

  assign bus.IREQ     = issue;
  assign bus.IADDR    = pc_q;
  assign bus.IF_VALID = head_valid;
  assign bus.IF_INSTR = head_instr;
  assign bus.IF_PC    = head_pc;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: SRAM model, program-order scoreboard, directed scenarios then random traffic.
module tb_inst_fetch;
  localparam int unsigned AW = 30;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   instr;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  inst_fetch_if #(.ADDR_W(AW)) bus ();

  inst_fetch #(.ADDR_W(AW), .RESET_PC('0), .DEPTH(2)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    return 32'h1000_0000 + 32'(a[AW-1:2]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SRAM: one-cycle read latency; garbage on idle cycles exposes stray captures.
  always @(posedge clk) begin
    if (bus.IREQ) bus.INSTR <= word_at(bus.IADDR);
    else          bus.INSTR <= $urandom;
  end

  // Reference model: program order restarts at reset/redirect target, +4 per instruction.
  exp_t          expq[$];
  logic [AW-1:0] next_pc;
  logic [AW-1:0] fetch_pc;
  logic          ireq_seen;
  logic [AW-1:0] last_acc_pc;
  logic [31:0]   last_acc_instr;
  int            idle;

  initial begin
    next_pc = '0; fetch_pc = '0; ireq_seen = 1'b0;
    last_acc_pc = '0; last_acc_instr = '0; idle = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      expq.delete();
      next_pc = '0;
      fetch_pc = '0;
      last_acc_pc = '0;
      last_acc_instr = '0;
    end else if (bus.REDIR_EN) begin
      expq.delete();
      next_pc = bus.REDIR_PC & ~AW'(3);
      fetch_pc = next_pc;
    end else if (ireq_seen) begin
      fetch_pc = fetch_pc + AW'(4);
    end
    while (expq.size() < 8) begin
      expq.push_back('{pc: next_pc, instr: word_at(next_pc)});
      next_pc = next_pc + AW'(4);
    end
  end

  // Monitor: compares every decode handshake against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    ireq_seen = bus.IREQ;
    if (rst) begin
      idle = 0;
    end else begin
      if (bus.IREQ) begin
        chk("iaddr", 64'(bus.IADDR), 64'(fetch_pc));
        if (!bus.RUN || bus.REDIR_EN) chk("ireq_blocked", 64'(bus.IREQ), 64'(0));
      end
      if (bus.IF_VALID && bus.ID_READY) begin
        if (expq.size() == 0) begin
          chk("sb_empty", 64'(1), 64'(0));
        end else begin
          e = expq.pop_front();
          chk("if_pc", 64'(bus.IF_PC), 64'(e.pc));
          chk("if_instr", 64'(bus.IF_INSTR), 64'(e.instr));
          last_acc_pc = e.pc;
          last_acc_instr = e.instr;
        end
      end
      if (bus.RUN && bus.ID_READY && !bus.REDIR_EN) begin
        if (bus.IF_VALID) idle = 0;
        else idle++;
        if (idle > 4) begin
          chk("throughput_stall", 64'(idle), 64'(0));
          idle = 0;
        end
      end else begin
        idle = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic run, input logic rdy);
    rst = 1'b1; bus.RUN = run; bus.ID_READY = rdy; bus.REDIR_EN = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    total = 0; bad = 0;
    rst = 1'b1; bus.RUN = 1'b0; bus.ID_READY = 1'b1;
    bus.REDIR_EN = 1'b0; bus.REDIR_PC = '0;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ireq", 64'(bus.IREQ), 64'(0));
    chk("rst_iaddr", 64'(bus.IADDR), 64'(0));
    chk("rst_valid", 64'(bus.IF_VALID), 64'(0));
    chk("rst_instr", 64'(bus.IF_INSTR), 64'(0));
    chk("rst_pc", 64'(bus.IF_PC), 64'(0));

    // Streaming from reset: valid two cycles after the first request.
    step(1);
    bus.RUN = 1'b1;
    @(negedge clk);
    chk("t1_ireq0", 64'(bus.IREQ), 64'(1));
    chk("t1_valid0", 64'(bus.IF_VALID), 64'(0));
    step(1); @(negedge clk);
    chk("t1_valid1", 64'(bus.IF_VALID), 64'(0));
    step(1); @(negedge clk);
    chk("t1_valid2", 64'(bus.IF_VALID), 64'(1));
    chk("t1_pc2", 64'(bus.IF_PC), 64'(0));
    step(12);

    // Decode stalled from the start: exactly DEPTH requests.
    do_reset(1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.IREQ) n++;
      step(1);
    end
    chk("t2_issues", 64'(n), 64'(2));
    @(negedge clk);
    chk("t2_valid", 64'(bus.IF_VALID), 64'(1));
    chk("t2_pc", 64'(bus.IF_PC), 64'(0));
    step(1);
    bus.ID_READY = 1'b1;
    step(10);

    // Redirect while 0x8 is in flight.
    do_reset(1'b1, 1'b1);
    step(3);
    bus.REDIR_EN = 1'b1; bus.REDIR_PC = AW'(32'h103);
    step(1);
    bus.REDIR_EN = 1'b0;
    @(negedge clk);
    chk("t3_ireq", 64'(bus.IREQ), 64'(1));
    chk("t3_iaddr", 64'(bus.IADDR), 64'(32'h100));
    chk("t3_valid", 64'(bus.IF_VALID), 64'(0));
    step(8);

    // Halt for 5 cycles mid-stream.
    bus.RUN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_halt_ireq", 64'(bus.IREQ), 64'(0));
      step(1);
    end
    @(negedge clk);
    chk("t4_drained", 64'(bus.IF_VALID), 64'(0));
    bus.RUN = 1'b1;
    step(10);

    // Reset with buffered word and a fetch in flight.
    do_reset(1'b1, 1'b0);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0; bus.ID_READY = 1'b1;
    @(negedge clk);
    chk("t5_valid0", 64'(bus.IF_VALID), 64'(0));
    chk("t5_iaddr", 64'(bus.IADDR), 64'(0));
    step(1); @(negedge clk);
    chk("t5_valid1", 64'(bus.IF_VALID), 64'(0));
    step(8);

    // Wrap at the top of the address space.
    bus.REDIR_EN = 1'b1; bus.REDIR_PC = AW'(32'h3FFF_FFFC);
    step(1);
    bus.REDIR_EN = 1'b0;
    @(negedge clk);
    chk("t6_iaddr_top", 64'(bus.IADDR), 64'(32'h3FFF_FFFC));
    step(1); @(negedge clk);
    chk("t6_iaddr_wrap", 64'(bus.IADDR), 64'(0));
    step(8);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      bus.RUN      = ($urandom_range(7) != 0);
      bus.ID_READY = ($urandom_range(3) != 0);
      bus.REDIR_EN = ($urandom_range(19) == 0);
      bus.REDIR_PC = AW'($urandom);
      rst          = ($urandom_range(149) == 0);
      step(1);
    end
    rst = 1'b0; bus.REDIR_EN = 1'b0; bus.RUN = 1'b1; bus.ID_READY = 1'b1;
    step(8);

    // Outputs hold the last delivered instruction once drained.
    bus.RUN = 1'b0;
    step(5);
    @(negedge clk);
    chk("hold_valid", 64'(bus.IF_VALID), 64'(0));
    chk("hold_pc", 64'(bus.IF_PC), 64'(last_acc_pc));
    chk("hold_instr", 64'(bus.IF_INSTR), 64'(last_acc_instr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
